goto_table_builder: RTL

- Writer side of the Aho-Corasick goto table. It consumes keyword characters one at a time and walks the trie being built.
- For each character it either follows an existing (current state, char) entry or allocates a new state and emits one goto-table write.
- Its write port fills the same three arrays the goto lookup reads: current state, char, next state, each indexed by entry address.
- It keeps a shadow copy of every written entry for its own searches.

---
 rtl/aho_pkg.sv | 31 +++
 rtl/goto_shadow_mem.sv | 33 +++
 rtl/goto_table_builder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/aho_pkg.sv
// Shared Aho-Corasick types and widths.
// Used by the goto-table builder and the goto lookup RAM.
package aho_pkg;

    localparam int ENTRIES = 32;
    localparam int ADDR_W  = 5;
    localparam int STATE_W = 8;
    localparam int CHAR_W  = 4;

    localparam logic [STATE_W-1:0] ROOT_STATE = '0;

    typedef struct packed {
        logic [STATE_W-1:0] current_state;
        logic [CHAR_W-1:0]  chara;
        logic [STATE_W-1:0] next_state;
    } goto_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_WRITE,
        ST_ERR
    } build_state_e;

    function automatic logic entry_hit(input goto_entry_t e,
                                       input logic [STATE_W-1:0] state,
                                       input logic [CHAR_W-1:0] chara);
        return (e.current_state == state) && (e.chara == chara);
    endfunction

endpackage

// File: rtl/goto_shadow_mem.sv
// Builder-private copy of the goto table: one write port and one
// combinational read port, both indexed by entry address.
module goto_shadow_mem
    import aho_pkg::*;
(
    input  logic              CLK,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  goto_entry_t       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output goto_entry_t       rdata_o
);

    logic [STATE_W-1:0] cur_mem_q  [ENTRIES];
    logic [CHAR_W-1:0]  char_mem_q [ENTRIES];
    logic [STATE_W-1:0] next_mem_q [ENTRIES];

    // NOTE: the arrays have no reset; rows at or above ENTRY_COUNT are never read for a compare.
    always_ff @(posedge CLK) begin
        if (we_i) begin
            cur_mem_q[waddr_i]  <= wdata_i.current_state;
            char_mem_q[waddr_i] <= wdata_i.chara;
            next_mem_q[waddr_i] <= wdata_i.next_state;
        end
    end

    always_comb begin
        rdata_o.current_state = cur_mem_q[raddr_i];
        rdata_o.chara         = char_mem_q[raddr_i];
        rdata_o.next_state    = next_mem_q[raddr_i];
    end

endmodule

// File: rtl/goto_table_builder.sv
// Goto-table writer: walks the trie one keyword character at a time and
// allocates a new state plus one table row for every unmatched transition.
module goto_table_builder
    import aho_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic [CHAR_W-1:0]  CHAR_IN,
    input  logic               CHAR_VALID,
    input  logic               CHAR_LAST,
    output logic               CHAR_READY,
    output logic               WR_EN,
    output logic [ADDR_W-1:0]  WR_ADDR,
    output logic [STATE_W-1:0] WR_CURRENT_STATE,
    output logic [CHAR_W-1:0]  WR_CHARA,
    output logic [STATE_W-1:0] WR_NEXT_STATE,
    output logic               KW_DONE,
    output logic [STATE_W-1:0] KW_STATE,
    output logic [ADDR_W:0]    ENTRY_COUNT,
    output logic               FULL_ERR
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(ENTRIES);

    build_state_e       state_q, state_d;
    logic [STATE_W-1:0] cur_state_q, cur_state_d;
    logic [STATE_W-1:0] free_state_q, free_state_d;
    logic [ADDR_W-1:0]  scan_q, scan_d;
    logic [CHAR_W-1:0]  char_q, char_d;
    logic               last_q, last_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    goto_entry_t        wr_row_q, wr_row_d;
    logic               kw_done_q, kw_done_d;
    logic [STATE_W-1:0] kw_state_q, kw_state_d;
    logic               full_err_q, full_err_d;

    goto_entry_t shadow_rd;
    logic        overflow;
    logic        hit;
    logic        scan_end;
    logic        enter_write;
    logic        wr_fire;

    // Table full, or the next state number would be the last representable one.
    assign overflow = (count_q == FULL_COUNT) || (free_state_q == '1);
    assign hit      = entry_hit(shadow_rd, cur_state_q, char_q);
    assign scan_end = ({1'b0, scan_q} == count_q - (ADDR_W+1)'(1));
    assign wr_fire  = (state_q == ST_WRITE) && !overflow;

    goto_shadow_mem u_shadow (
        .CLK     (CLK),
        .we_i    (wr_fire),
        .waddr_i (wr_addr_q),
        .wdata_i (wr_row_q),
        .raddr_i (scan_q),
        .rdata_o (shadow_rd)
    );

    // NOTE: every next-state value takes its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        cur_state_d  = cur_state_q;
        free_state_d = free_state_q;
        scan_d       = scan_q;
        char_d       = char_q;
        last_d       = last_q;
        count_d      = count_q;
        wr_addr_d    = wr_addr_q;
        wr_row_d     = wr_row_q;
        kw_done_d    = 1'b0;
        kw_state_d   = kw_state_q;
        full_err_d   = full_err_q;
        enter_write  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (CHAR_VALID) begin
                    char_d = CHAR_IN;
                    last_d = CHAR_LAST;
                    scan_d = '0;
                    if (count_q != '0) begin
                        state_d = ST_SEARCH;
                    end else begin
                        state_d     = ST_WRITE;
                        enter_write = 1'b1;
                    end
                end
            end
            ST_SEARCH: begin
                if (hit) begin
                    state_d = ST_IDLE;
                    if (last_q) begin
                        kw_done_d   = 1'b1;
                        kw_state_d  = shadow_rd.next_state;
                        cur_state_d = ROOT_STATE;
                    end else begin
                        cur_state_d = shadow_rd.next_state;
                    end
                end else if (scan_end) begin
                    state_d     = ST_WRITE;
                    enter_write = 1'b1;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            ST_WRITE: begin
                if (overflow) begin
                    full_err_d = 1'b1;
                    state_d    = ST_ERR;
                end else begin
                    count_d      = count_q + 1'b1;
                    free_state_d = free_state_q + 1'b1;
                    state_d      = ST_IDLE;
                    if (last_q) begin
                        kw_done_d   = 1'b1;
                        kw_state_d  = free_state_q;
                        cur_state_d = ROOT_STATE;
                    end else begin
                        cur_state_d = free_state_q;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Row registers load on entry to WRITE so they are stable for the whole strobe.
        if (enter_write && !overflow) begin
            wr_addr_d               = count_q[ADDR_W-1:0];
            wr_row_d.current_state  = cur_state_q;
            wr_row_d.chara          = char_d;
            wr_row_d.next_state     = free_state_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            cur_state_q  <= ROOT_STATE;
            free_state_q <= STATE_W'(1);
            scan_q       <= '0;
            char_q       <= '0;
            last_q       <= 1'b0;
            count_q      <= '0;
            wr_addr_q    <= '0;
            wr_row_q     <= '0;
            kw_done_q    <= 1'b0;
            kw_state_q   <= '0;
            full_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_state_q  <= cur_state_d;
            free_state_q <= free_state_d;
            scan_q       <= scan_d;
            char_q       <= char_d;
            last_q       <= last_d;
            count_q      <= count_d;
            wr_addr_q    <= wr_addr_d;
            wr_row_q     <= wr_row_d;
            kw_done_q    <= kw_done_d;
            kw_state_q   <= kw_state_d;
            full_err_q   <= full_err_d;
        end
    end

    assign CHAR_READY       = (state_q == ST_IDLE);
    assign WR_EN            = wr_fire;
    assign WR_ADDR          = wr_addr_q;
    assign WR_CURRENT_STATE = wr_row_q.current_state;
    assign WR_CHARA         = wr_row_q.chara;
    assign WR_NEXT_STATE    = wr_row_q.next_state;
    assign KW_DONE          = kw_done_q;
    assign KW_STATE         = kw_state_q;
    assign ENTRY_COUNT      = count_q;
    assign FULL_ERR         = full_err_q;

endmodule
